// File: rtl/bonus_ship_path.sv
// rtl/bonus_ship_path.sv - bonus ship that flies in, turns and dwells at a random destination, then exits
// Fixed-point X/Y position; states IDLE -> MOVE <-> DWELL -> EXIT, killed by hit from any live state.
module bonus_ship_path #(
   parameter int INITIAL_Y    = 64,
   parameter int X_SPEED      = 40,
   parameter int FRAC_BITS    = 6,
   parameter int NUM_TURNS    = 2,
   parameter int DWELL_FRAMES = 90,
   parameter int START_LEFT   = 1,
   parameter int Y_STEP       = 0,
   parameter int SCREEN_W     = 640,
   parameter int OBJ_W        = 64,
   parameter int MIN_DEST     = 450,
   parameter int SPAWN_Y_MIN  = 100
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               playGame,
   input  logic               hit,
   input  logic signed [10:0] alienMatrixYPosition,
   input  logic [9:0]         randX,
   output logic signed [10:0] topLeftX,
   output logic signed [10:0] topLeftY,
   output logic               alive,
   output logic               destroyed,
   output logic               escaped,
   output logic [3:0]         turnsLeft
);

   localparam int W = 11 + FRAC_BITS;
   localparam logic signed [W-1:0] X_LEFT_SPAWN  = W'(-OBJ_W * (1 << FRAC_BITS));
   localparam logic signed [W-1:0] X_RIGHT_SPAWN = W'(SCREEN_W * (1 << FRAC_BITS));
   localparam logic signed [W-1:0] Y_SPAWN       = W'(INITIAL_Y * (1 << FRAC_BITS));
   localparam logic signed [W-1:0] X_STEP        = W'(X_SPEED);
   localparam logic signed [W-1:0] Y_INC         = W'(Y_STEP * (1 << FRAC_BITS));
   localparam logic signed [10:0]  SCR_W         = 11'(SCREEN_W);
   localparam logic signed [10:0]  X_OFF_LEFT    = 11'(-OBJ_W);
   localparam logic signed [10:0]  Y_MIN         = 11'(SPAWN_Y_MIN);
   localparam logic [9:0]          DEST_MAX      = 10'(SCREEN_W - OBJ_W);
   localparam logic [9:0]          MIN_D         = 10'(MIN_DEST);
   localparam logic [9:0]          DWELL_V       = 10'(DWELL_FRAMES);
   localparam logic [3:0]          TURNS_V       = 4'(NUM_TURNS);
   localparam logic                START_RIGHT   = (START_LEFT != 0);

   typedef enum logic [1:0] {IDLE, MOVE, DWELL, EXIT} state_t;

   state_t                state, state_n;
   logic signed [W-1:0]   x_fp, x_fp_n, y_fp, y_fp_n, x_step;
   logic signed [10:0]    x_step_int, target;
   logic                  dir_right, dir_right_n;
   logic [9:0]            dest, dest_n, last_dest, last_dest_n, dwell_cnt, dwell_cnt_n;
   logic [3:0]            turns_n;
   logic                  destroyed_n, escaped_n;

   always_comb begin
      x_step      = dir_right ? x_fp + X_STEP : x_fp - X_STEP;
      x_step_int  = 11'(x_step >>> FRAC_BITS);
      target      = dir_right ? signed'({1'b0, dest}) : SCR_W - signed'({1'b0, dest});
      state_n     = state;
      x_fp_n      = x_fp;
      y_fp_n      = y_fp;
      dir_right_n = dir_right;
      dest_n      = dest;
      last_dest_n = last_dest;
      dwell_cnt_n = dwell_cnt;
      turns_n     = turnsLeft;
      destroyed_n = 1'b0;
      escaped_n   = 1'b0;
      case (state)
         IDLE: begin
            if (playGame && alienMatrixYPosition > Y_MIN && randX >= MIN_D && randX != last_dest) begin
               state_n     = MOVE;
               dest_n      = (randX > DEST_MAX) ? DEST_MAX : randX;
               last_dest_n = randX;
               x_fp_n      = START_RIGHT ? X_LEFT_SPAWN : X_RIGHT_SPAWN;
               y_fp_n      = Y_SPAWN;
               turns_n     = TURNS_V;
               dir_right_n = START_RIGHT;
            end
         end
         MOVE: begin
            if (startOfFrame) begin
               if (dir_right ? (x_step_int >= target) : (x_step_int <= target)) begin
                  x_fp_n      = W'(target) <<< FRAC_BITS;
                  y_fp_n      = y_fp + Y_INC;
                  turns_n     = turnsLeft - 4'd1;
                  dwell_cnt_n = DWELL_V;
                  state_n     = DWELL;
               end else begin
                  x_fp_n = x_step;
               end
            end
         end
         DWELL: begin
            if (startOfFrame) begin
               dwell_cnt_n = dwell_cnt - 10'd1;
               if (dwell_cnt == 10'd1) begin
                  dir_right_n = !dir_right;
                  state_n     = (turnsLeft != 4'd0) ? MOVE : EXIT;
               end
            end
         end
         EXIT: begin
            if (startOfFrame) begin
               x_fp_n = x_step;
               if (dir_right ? (x_step_int >= SCR_W) : (x_step_int <= X_OFF_LEFT)) begin
                  state_n   = IDLE;
                  escaped_n = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      // A kill freezes the ship where it is and overrides any same-cycle move, turn or escape.
      if (hit && state != IDLE) begin
         state_n     = IDLE;
         destroyed_n = 1'b1;
         escaped_n   = 1'b0;
         x_fp_n      = x_fp;
         y_fp_n      = y_fp;
         dir_right_n = dir_right;
         dwell_cnt_n = dwell_cnt;
         turns_n     = turnsLeft;
      end
   end

   always_ff @(posedge clk) begin
      if (resetN || !playGame) begin
         state     <= IDLE;
         x_fp      <= X_LEFT_SPAWN;
         y_fp      <= Y_SPAWN;
         dir_right <= START_RIGHT;
         dest      <= 10'd0;
         last_dest <= 10'd0;
         dwell_cnt <= 10'd0;
         turnsLeft <= 4'd0;
         destroyed <= 1'b0;
         escaped   <= 1'b0;
      end else begin
         state     <= state_n;
         x_fp      <= x_fp_n;
         y_fp      <= y_fp_n;
         dir_right <= dir_right_n;
         dest      <= dest_n;
         last_dest <= last_dest_n;
         dwell_cnt <= dwell_cnt_n;
         turnsLeft <= turns_n;
         destroyed <= destroyed_n;
         escaped   <= escaped_n;
      end
   end

   assign topLeftX = 11'(x_fp >>> FRAC_BITS);
   assign topLeftY = 11'(y_fp >>> FRAC_BITS);
   assign alive    = (state != IDLE);

endmodule

// File: tb/tb_bonus_ship_path.sv
// tb/tb_bonus_ship_path.sv - directed bench for bonus_ship_path with a pulse scoreboard
// Instance a enters from the left with Y_STEP=8; instance b enters from the right.
module tb_bonus_ship_path;

   logic clk = 1'b0;
   logic resetN, sof, play_a, play_b, hit_a, hit_b;
   logic signed [10:0] alien_y;
   logic [9:0] rand_x;
   logic signed [10:0] x_a, y_a, x_b, y_b;
   logic alive_a, alive_b, destroyed_a, destroyed_b, escaped_a, escaped_b;
   logic [3:0] turns_a, turns_b;

   int checks = 0;
   int failures = 0;

   typedef struct {int inst; int kind; int x;} ev_t;
   ev_t sb[$];

   always #5 clk = ~clk;

   bonus_ship_path #(.X_SPEED(64), .START_LEFT(1), .Y_STEP(8)) dut_a (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .playGame(play_a), .hit(hit_a),
      .alienMatrixYPosition(alien_y), .randX(rand_x), .topLeftX(x_a), .topLeftY(y_a),
      .alive(alive_a), .destroyed(destroyed_a), .escaped(escaped_a), .turnsLeft(turns_a));

   bonus_ship_path #(.X_SPEED(64), .START_LEFT(0), .Y_STEP(8)) dut_b (
      .clk(clk), .resetN(resetN), .startOfFrame(sof), .playGame(play_b), .hit(hit_b),
      .alienMatrixYPosition(alien_y), .randX(rand_x), .topLeftX(x_b), .topLeftY(y_b),
      .alive(alive_b), .destroyed(destroyed_b), .escaped(escaped_b), .turnsLeft(turns_b));

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         sof = 1'b1;
         tick();
         sof = 1'b0;
         tick();
      end
   endtask

   task automatic expect_pulse(input int inst, input int kind, input int x);
      ev_t e;
      e.inst = inst;
      e.kind = kind;
      e.x    = x;
      sb.push_back(e);
   endtask

   // kind 0 = destroyed, 1 = escaped
   always @(negedge clk) begin
      if (destroyed_a || escaped_a || destroyed_b || escaped_b) begin
         ev_t e;
         int inst, kind, x;
         inst = (destroyed_b || escaped_b) ? 1 : 0;
         kind = (escaped_a || escaped_b) ? 1 : 0;
         x    = (inst == 1) ? int'(x_b) : int'(x_a);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", kind, -1);
         end else begin
            e = sb.pop_front();
            chk("pulse_inst", inst, e.inst);
            chk("pulse_kind", kind, e.kind);
            chk("pulse_x", x, e.x);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetN = 1'b1; sof = 1'b0; play_a = 1'b1; play_b = 1'b0;
      hit_a = 1'b0; hit_b = 1'b0; alien_y = 11'sd0; rand_x = 10'd0;
      repeat (3) tick();
      resetN = 1'b0;
      tick();
      chk("rst_alive", int'(alive_a), 0);
      chk("rst_x", int'(x_a), -64);
      chk("rst_y", int'(y_a), 64);
      chk("rst_turns", int'(turns_a), 0);
      chk("rst_destroyed", int'(destroyed_a), 0);
      chk("rst_escaped", int'(escaped_a), 0);

      alien_y = 11'sd120; rand_x = 10'd449;
      tick();
      chk("no_spawn_449", int'(alive_a), 0);
      alien_y = 11'sd100; rand_x = 10'd500;
      tick();
      chk("no_spawn_y100", int'(alive_a), 0);

      // main flight: dest 500, turns at 500 and 140, exit right
      alien_y = 11'sd120;
      tick();
      rand_x = 10'd0;
      chk("spawn_alive", int'(alive_a), 1);
      chk("spawn_x", int'(x_a), -64);
      chk("spawn_turns", int'(turns_a), 2);
      tick();
      chk("no_frame_hold_x", int'(x_a), -64);
      frames(563);
      chk("pre_turn1_x", int'(x_a), 499);
      frames(1);
      chk("turn1_x", int'(x_a), 500);
      chk("turn1_turns", int'(turns_a), 1);
      chk("turn1_y", int'(y_a), 72);
      frames(89);
      chk("dwell_hold_x", int'(x_a), 500);
      frames(1);
      chk("dwell_end_x", int'(x_a), 500);
      frames(1);
      chk("move_left_x", int'(x_a), 499);
      frames(359);
      chk("turn2_x", int'(x_a), 140);
      chk("turn2_turns", int'(turns_a), 0);
      chk("turn2_y", int'(y_a), 80);
      frames(90);
      chk("exit_start_x", int'(x_a), 140);
      frames(499);
      chk("pre_escape_x", int'(x_a), 639);
      chk("pre_escape_alive", int'(alive_a), 1);
      expect_pulse(0, 1, 640);
      frames(1);
      chk("post_escape_alive", int'(alive_a), 0);
      chk("escape_one_cycle", int'(escaped_a), 0);

      // kill during flight, repeat-destination lockout
      rand_x = 10'd500;
      tick();
      chk("repeat_dest_no_spawn", int'(alive_a), 0);
      rand_x = 10'd501;
      tick();
      rand_x = 10'd0;
      chk("respawn_alive", int'(alive_a), 1);
      frames(10);
      chk("hit_frame10_x", int'(x_a), -54);
      hit_a = 1'b1;
      expect_pulse(0, 0, -54);
      tick();
      hit_a = 1'b0;
      chk("hit_alive", int'(alive_a), 0);
      hit_a = 1'b1;
      tick();
      hit_a = 1'b0;
      tick();
      chk("idle_hit_ignored", int'(alive_a), 0);
      rand_x = 10'd501;
      tick();
      chk("repeat_501_no_spawn", int'(alive_a), 0);

      // clamp to 576, then hit on the dwell-expiry frame
      rand_x = 10'd639;
      tick();
      rand_x = 10'd0;
      chk("clamp_spawn_alive", int'(alive_a), 1);
      frames(639);
      chk("clamp_pre_x", int'(x_a), 575);
      frames(1);
      chk("clamp_x", int'(x_a), 576);
      chk("clamp_turns", int'(turns_a), 1);
      frames(89);
      sof = 1'b1; hit_a = 1'b1;
      expect_pulse(0, 0, 576);
      tick();
      sof = 1'b0; hit_a = 1'b0;
      tick();
      chk("hit_prio_alive", int'(alive_a), 0);

      // playGame drop in DWELL
      rand_x = 10'd500;
      tick();
      rand_x = 10'd0;
      frames(564);
      chk("drop_dwell_x", int'(x_a), 500);
      frames(3);
      play_a = 1'b0;
      tick();
      chk("drop_alive", int'(alive_a), 0);
      chk("drop_x", int'(x_a), -64);
      chk("drop_y", int'(y_a), 64);
      chk("drop_turns", int'(turns_a), 0);

      // right-entry instance
      play_b = 1'b1; rand_x = 10'd500;
      tick();
      rand_x = 10'd0;
      chk("b_spawn_alive", int'(alive_b), 1);
      chk("b_spawn_x", int'(x_b), 640);
      chk("b_spawn_turns", int'(turns_b), 2);
      frames(499);
      chk("b_pre_turn1_x", int'(x_b), 141);
      frames(1);
      chk("b_turn1_x", int'(x_b), 140);
      chk("b_turn1_turns", int'(turns_b), 1);
      frames(90);
      frames(360);
      chk("b_turn2_x", int'(x_b), 500);
      chk("b_turn2_turns", int'(turns_b), 0);
      frames(90);
      frames(563);
      chk("b_pre_escape_x", int'(x_b), -63);
      expect_pulse(1, 1, -64);
      frames(1);
      chk("b_post_escape_alive", int'(alive_b), 0);

      tick();
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bonus_ship_path.md
BONUS_SHIP_PATH -- requirements
Module: bonus_ship_path

Interface
REQ-001 Parameter INITIAL_Y, default 64, sets the spawn row in pixels.
REQ-002 Parameter X_SPEED, default 40, sets horizontal speed in 1/2^FRAC_BITS px per frame; it is positive and the sign is applied internally.
REQ-003 Parameter FRAC_BITS, default 6, sets the fixed-point fraction bits of the position registers.
REQ-004 Parameter NUM_TURNS, default 2, range 1..15, sets how many turn-and-dwell points occur before exit.
REQ-005 Parameter DWELL_FRAMES, default 90, range 1..1023, sets how many startOfFrame pulses are held at each turn point.
REQ-006 Parameter START_LEFT, default 1: 1 = enter from the left moving right; 0 = enter from the right moving left.
REQ-007 Parameter Y_STEP, default 0, sets the pixels added to Y at each turn (descent).
REQ-008 Parameters SCREEN_W 640, OBJ_W 64, MIN_DEST 450, SPAWN_Y_MIN 100.
REQ-009 clk  in  1  system clock; all logic on rising edge.
REQ-010 resetN  in  1  synchronous, active-high reset (name kept per codebase; asserted = 1).
REQ-011 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-012 playGame  in  1  game-running qualifier; low acts as a synchronous soft reset.
REQ-013 hit  in  1  collision of player fire with ship.
REQ-014 alienMatrixYPosition  in  11 signed  alien block top row.
REQ-015 randX  in  10  pseudo-random destination candidate.
REQ-016 topLeftX, topLeftY  out  11 signed each  integer pixel position = fixed-point value >>> FRAC_BITS (arithmetic).
REQ-017 alive  out  1  high while state is not IDLE.
REQ-018 destroyed  out  1  one-cycle pulse on hit kill.
REQ-019 escaped  out  1  one-cycle pulse on leaving screen.
REQ-020 turnsLeft  out  4  remaining turn points.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, MOVE, DWELL, EXIT.
REQ-022 IDLE->MOVE SHALL occur when playGame=1, alienMatrixYPosition > SPAWN_Y_MIN, randX >= MIN_DEST and randX != lastDest, all in the same cycle.
REQ-023 At spawn: dest = min(randX, SCREEN_W-OBJ_W); lastDest <= randX; X = -OBJ_W if START_LEFT=1 else SCREEN_W; Y = INITIAL_Y; turnsLeft = NUM_TURNS; direction = right if START_LEFT=1 else left.
REQ-024 The turn target SHALL be dest when moving right and SCREEN_W-dest when moving left.
REQ-025 In MOVE/EXIT, on each startOfFrame X SHALL change by +/-X_SPEED per direction; X SHALL not change on non-frame cycles.
REQ-026 In MOVE, once the integer X reaches or passes the target (>= moving right, <= moving left), X SHALL snap to target<<FRAC_BITS, Y += Y_STEP, turnsLeft decrements, dwell counter loads DWELL_FRAMES, and the state goes to DWELL.
REQ-027 In DWELL, the counter SHALL decrement on each startOfFrame; on the startOfFrame that takes it to 0, direction inverts and the state goes to MOVE if turnsLeft>0, else to EXIT.
REQ-028 In EXIT, the block SHALL go to IDLE with escaped=1 for one cycle when integer X >= SCREEN_W (moving right) or X <= -OBJ_W (moving left).
REQ-029 hit in any non-IDLE state SHALL go to IDLE with destroyed=1 for one cycle; hit has priority over all other transitions, including the same-cycle arrival, dwell expiry or escape.
REQ-030 hit in IDLE SHALL be ignored; a spawn cannot occur in the same cycle as a kill.
REQ-031 playGame=0 SHALL load the reset values on the next edge, regardless of state.
REQ-032 The fixed-point registers SHALL be signed, 11+FRAC_BITS bits wide, and SHALL not wrap within [-OBJ_W, SCREEN_W+X_SPEED].

Reset
REQ-033 On resetN=1: state IDLE, alive 0, destroyed 0, escaped 0, turnsLeft 0, topLeftX = -OBJ_W, topLeftY = INITIAL_Y, lastDest 0, dwell counter 0.
REQ-034 A reset mid-flight SHALL abort immediately with no escaped or destroyed pulse.

Verification
REQ-035 X_SPEED=64, START_LEFT=1, randX=500, alienY=120 -> alive=1 next cycle, X=-64; after 564 frames X=500 and DWELL; after 90 frames X moves left.
REQ-036 Continuation of REQ-035 -> second turn at X=140 with turnsLeft=0; after dwell, EXIT rightward; escaped pulse when X=640, then alive=0.
REQ-037 hit asserted at frame 10 of flight -> destroyed=1 for one cycle, alive=0; a repeated randX=500 does not respawn; randX=501 does.
REQ-038 randX=449 or alienY=100 -> no spawn; randX=639 -> dest clamped to 576.
REQ-039 playGame dropped in DWELL -> next cycle in IDLE, X=-64, no pulses; Y_STEP=8 -> Y=72 after the first turn.
REQ-040 START_LEFT=0, randX=500 -> spawn X=640, first target 140, exit leftward at X<=-64.
